// File: rtl/reg_bank_decoded.sv
// Register bank with a one-hot write decoder, global enable, two registered read
// ports with same-cycle write bypass, a per-register valid bitmap and a write strobe.
module reg_bank_decoded #(
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      waddr,
  input  logic [DATA_W-1:0]      wdata,
  input  logic                   clr,
  input  logic [ADDR_W-1:0]      raddr_a,
  input  logic [ADDR_W-1:0]      raddr_b,
  output logic [DATA_W-1:0]      rdata_a,
  output logic [DATA_W-1:0]      rdata_b,
  output logic [0:(1<<ADDR_W)-1] wsel,
  output logic [(1<<ADDR_W)-1:0] vld
);

  localparam int NREG = 1 << ADDR_W;

  logic [DATA_W-1:0] mem [NREG];
  logic [0:NREG-1]   dec;
  logic              accept;

  // Decoder output is gated by en; clr only blocks the write from landing.
  always_comb begin
    dec = '0;
    if (en && we) dec[waddr] = 1'b1;
    accept = en && we && !clr;
  end

  // Read data reflects the register contents after this edge: clr forces zero,
  // an accepted write to the same address is forwarded as new data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
      vld     <= '0;
      wsel    <= '0;
      rdata_a <= '0;
      rdata_b <= '0;
    end else if (clr) begin
      for (int i = 0; i < NREG; i++) mem[i] <= '0;
      vld     <= '0;
      wsel    <= '0;
      rdata_a <= '0;
      rdata_b <= '0;
    end else begin
      if (accept) begin
        mem[waddr] <= wdata;
        vld[waddr] <= 1'b1;
      end
      wsel    <= accept ? dec : '0;
      rdata_a <= (accept && (raddr_a == waddr)) ? wdata : mem[raddr_a];
      rdata_b <= (accept && (raddr_b == waddr)) ? wdata : mem[raddr_b];
    end
  end

endmodule

// File: tb/tb_reg_bank_decoded.sv
// Bench for reg_bank_decoded: directed scenarios plus randomized traffic checked
// against an array model of the register contents after each edge.
module tb_reg_bank_decoded;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       we;
  logic [2:0] waddr;
  logic [7:0] wdata;
  logic       clr;
  logic [2:0] raddr_a;
  logic [2:0] raddr_b;
  logic [7:0] rdata_a;
  logic [7:0] rdata_b;
  logic [0:7] wsel;
  logic [7:0] vld;

  int n_cmp;
  int n_fail;

  // Model: register contents and valid flags as seen after the latest edge.
  logic [7:0] model_mem [8];
  bit         model_vld [8];
  logic [7:0] exp_a;
  logic [7:0] exp_b;
  logic [7:0] exp_wsel;
  logic [7:0] exp_vld;

  reg_bank_decoded #(.ADDR_W(3), .DATA_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .we(we), .waddr(waddr), .wdata(wdata),
    .clr(clr), .raddr_a(raddr_a), .raddr_b(raddr_b), .rdata_a(rdata_a),
    .rdata_b(rdata_b), .wsel(wsel), .vld(vld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      model_mem[i] = 8'h00;
      model_vld[i] = 1'b0;
    end
  endtask

  function automatic logic [7:0] model_vld_vec();
    logic [7:0] v;
    v = 8'h00;
    for (int i = 0; i < 8; i++) if (model_vld[i]) v = v | (8'h01 << i);
    return v;
  endfunction

  // Drive one cycle of inputs, advance the model across the edge, land #1 after it.
  task automatic cycle(input logic e, input logic w, input logic [2:0] wa,
                       input logic [7:0] wd, input logic c,
                       input logic [2:0] ra, input logic [2:0] rb);
    en = e; we = w; waddr = wa; wdata = wd; clr = c; raddr_a = ra; raddr_b = rb;
    @(posedge clk);
    exp_wsel = 8'h00;
    if (c) begin
      model_reset();
    end else if (e && w) begin
      model_mem[wa] = wd;
      model_vld[wa] = 1'b1;
      exp_wsel = 8'h80 >> wa;
    end
    exp_a   = model_mem[ra];
    exp_b   = model_mem[rb];
    exp_vld = model_vld_vec();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; we = 1'b1; waddr = 3'd2; wdata = 8'hFF; clr = 1'b0;
    raddr_a = 3'd2; raddr_b = 3'd2;
    model_reset();
    #1;
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({rdata_a, rdata_b, wsel, vld} !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_hold: outputs=%h required=00000000", {rdata_a, rdata_b, wsel, vld});
      end
      waddr = 3'(k);
      @(posedge clk); #1;
    end
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'(i), 3'(7 - i));
      n_cmp++;
      if (rdata_a !== 8'h00 || rdata_b !== 8'h00 || vld !== 8'h00) begin
        n_fail++;
        $display("FAIL reset_read[%0d]: a=%h b=%h vld=%h required 00/00/00", i, rdata_a, rdata_b, vld);
      end
    end
  endtask

  task automatic test_decoder_sweep();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, 3'(i), 8'h10 + 8'(i), 1'b0, 3'd0, 3'd0);
      n_cmp++;
      if (wsel !== (8'h80 >> i)) begin
        n_fail++;
        $display("FAIL sweep_wsel[%0d]: got=%b required=%b", i, wsel, 8'h80 >> i);
      end
    end
    n_cmp++;
    if (vld !== 8'hFF) begin
      n_fail++;
      $display("FAIL sweep_vld: got=%h required=ff", vld);
    end
    cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd5, 3'd7);
    n_cmp++;
    if (rdata_a !== 8'h15 || rdata_b !== 8'h17 || wsel !== 8'h00) begin
      n_fail++;
      $display("FAIL sweep_read: a=%h b=%h wsel=%b required 15/17/00000000", rdata_a, rdata_b, wsel);
    end
  endtask

  task automatic test_enable();
    cycle(1'b0, 1'b1, 3'd3, 8'hAA, 1'b0, 3'd3, 3'd3);
    n_cmp++;
    if (wsel !== 8'h00 || vld !== 8'hFF || rdata_a !== 8'h13 || rdata_b !== 8'h13) begin
      n_fail++;
      $display("FAIL enable_low: wsel=%b vld=%h a=%h b=%h required 00000000/ff/13/13", wsel, vld, rdata_a, rdata_b);
    end
    cycle(1'b1, 1'b1, 3'd3, 8'hAA, 1'b0, 3'd4, 3'd4);
    n_cmp++;
    if (wsel !== 8'b0001_0000) begin
      n_fail++;
      $display("FAIL enable_high_wsel: got=%b required=00010000", wsel);
    end
    cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd3, 3'd0);
    n_cmp++;
    if (rdata_a !== 8'hAA || wsel !== 8'h00) begin
      n_fail++;
      $display("FAIL enable_high_read: a=%h wsel=%b required aa/00000000", rdata_a, wsel);
    end
  endtask

  task automatic test_bypass();
    cycle(1'b1, 1'b1, 3'd6, 8'h5C, 1'b0, 3'd6, 3'd2);
    n_cmp++;
    if (rdata_a !== 8'h5C || rdata_b !== 8'h12) begin
      n_fail++;
      $display("FAIL bypass: a=%h b=%h required 5c/12", rdata_a, rdata_b);
    end
  endtask

  task automatic test_back_to_back();
    cycle(1'b1, 1'b1, 3'd0, 8'h31, 1'b0, 3'd0, 3'd1);
    cycle(1'b1, 1'b1, 3'd0, 8'h32, 1'b0, 3'd0, 3'd0);
    n_cmp++;
    if (wsel !== 8'h80 || rdata_a !== 8'h32) begin
      n_fail++;
      $display("FAIL back_to_back: wsel=%b a=%h required 10000000/32", wsel, rdata_a);
    end
    cycle(1'b1, 1'b1, 3'd7, 8'h47, 1'b0, 3'd0, 3'd7);
    n_cmp++;
    if (wsel !== 8'h01 || rdata_a !== 8'h32 || rdata_b !== 8'h47 || vld !== 8'hFF) begin
      n_fail++;
      $display("FAIL back_to_back_2: wsel=%b a=%h b=%h vld=%h required 00000001/32/47/ff", wsel, rdata_a, rdata_b, vld);
    end
  endtask

  task automatic test_clear();
    cycle(1'b1, 1'b1, 3'd1, 8'h77, 1'b1, 3'd1, 3'd6);
    n_cmp++;
    if (vld !== 8'h00 || wsel !== 8'h00 || rdata_a !== 8'h00 || rdata_b !== 8'h00) begin
      n_fail++;
      $display("FAIL clear: vld=%h wsel=%b a=%h b=%h required all zero", vld, wsel, rdata_a, rdata_b);
    end
    cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd1, 3'd6);
    n_cmp++;
    if (rdata_a !== 8'h00 || rdata_b !== 8'h00) begin
      n_fail++;
      $display("FAIL clear_read: a=%h b=%h required 00/00", rdata_a, rdata_b);
    end
  endtask

  task automatic test_random();
    logic [7:0] exp_q [$];
    logic [7:0] e;
    for (int k = 0; k < 300; k++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
            8'($urandom), 1'($urandom_range(0, 19) == 0),
            3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
      exp_q.push_back(exp_a);
      exp_q.push_back(exp_b);
      e = exp_q.pop_front();
      n_cmp++;
      if (rdata_a !== e) begin
        n_fail++;
        $display("FAIL random_rdata_a[%0d]: got=%h required=%h", k, rdata_a, e);
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (rdata_b !== e) begin
        n_fail++;
        $display("FAIL random_rdata_b[%0d]: got=%h required=%h", k, rdata_b, e);
      end
      n_cmp++;
      if (wsel !== exp_wsel || vld !== exp_vld) begin
        n_fail++;
        $display("FAIL random_flags[%0d]: wsel=%b vld=%h required %b/%h", k, wsel, vld, exp_wsel, exp_vld);
      end
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b1, 3'(i), 8'hC0 | 8'(i), 1'b0, 3'(i), 3'd0);
    en = 1'b1; we = 1'b1; waddr = 3'd4; wdata = 8'hEE; raddr_a = 3'd4; raddr_b = 3'd7;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({rdata_a, rdata_b, wsel, vld} !== 32'h0) begin
      n_fail++;
      $display("FAIL async_reset: outputs=%h required=00000000", {rdata_a, rdata_b, wsel, vld});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'(i), 3'(i));
      n_cmp++;
      if (rdata_a !== 8'h00 || rdata_b !== 8'h00 || vld !== 8'h00) begin
        n_fail++;
        $display("FAIL async_reset_read[%0d]: a=%h b=%h vld=%h required 00/00/00", i, rdata_a, rdata_b, vld);
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    test_reset();
    test_decoder_sweep();
    test_enable();
    test_bypass();
    test_back_to_back();
    test_clear();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
